ro_count_sender: RTL and testbench

RO_COUNT_SENDER -- requirements
Module: ro_count_sender

---
 rtl/ro_puf_pkg.sv | 19 +
 rtl/ro_count_sender_bit_sync.sv | 29 ++
 rtl/ro_count_sender.sv | 162 ++++++++++++++++
 tb/tb_ro_count_sender.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator count sender: default widths and
// the transmit-side state type.
package ro_puf_pkg;

   localparam int RO_COUNT_W_DEF     = 16;
   localparam int RO_SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ACK   = 2'd3
   } ro_tx_state_t;

   function automatic logic ro_state_busy(input ro_tx_state_t s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/ro_count_sender_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
// STAGES must be at least 2.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ro_count_sender.sv
// Counts ring-oscillator edges while enabled and hands the captured count to
// a requester over a four-phase req/ack handshake, all clocked by the RO.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | counter cleared, waiting for enable or a read request
//   ST_COUNT | counting one per edge (saturating)
//   ST_HOLD  | enable dropped, count frozen until resume or read
//   ST_ACK   | count captured, ack high until req is released
module ro_count_sender
   import ro_puf_pkg::*;
#(
   parameter int COUNT_W     = RO_COUNT_W_DEF,
   parameter int SYNC_STAGES = RO_SYNC_STAGES_DEF
) (
   input  logic               count_clk,
   input  logic               reset,
   input  logic               en,
   input  logic               req,
   output logic               ack,
   output logic [COUNT_W-1:0] count_data,
   output logic               overflow,
   output logic               busy
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic en_s;
   logic req_s;

   ro_tx_state_t       state_q, state_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic               ack_q, ack_d;
   logic [COUNT_W-1:0] count_data_q, count_data_d;
   logic               overflow_q, overflow_d;

   logic               cnt_at_max;
   logic [COUNT_W-1:0] cnt_inc;
   logic               sat_inc;

   bit_sync #(.STAGES(SYNC_STAGES)) u_en_sync (
      .clk   (count_clk),
      .reset (reset),
      .d     (en),
      .q     (en_s)
   );

   bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (count_clk),
      .reset (reset),
      .d     (req),
      .q     (req_s)
   );

   // Saturating increment: at the top value the count sticks and sat records
   // the lost edge instead of wrapping.
   always_comb begin
      cnt_at_max = (cnt_q == CNT_MAX);
      cnt_inc    = cnt_at_max ? cnt_q : (cnt_q + CNT_ONE);
      sat_inc    = sat_q | cnt_at_max;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sat_d        = sat_q;
      ack_d        = ack_q;
      count_data_d = count_data_q;
      overflow_d   = overflow_q;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            sat_d = 1'b0;
            ack_d = 1'b0;
            if (req_s) begin
               state_d      = ST_ACK;
               count_data_d = '0;
               overflow_d   = 1'b0;
               ack_d        = 1'b1;
            end else if (en_s) begin
               state_d = ST_COUNT;
               cnt_d   = cnt_inc;
               sat_d   = sat_inc;
            end
         end

         ST_COUNT: begin
            if (req_s) begin
               state_d      = ST_ACK;
               count_data_d = cnt_q;
               overflow_d   = sat_q;
               ack_d        = 1'b1;
               cnt_d        = '0;
               sat_d        = 1'b0;
            end else if (!en_s) begin
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_inc;
               sat_d = sat_inc;
            end
         end

         ST_HOLD: begin
            if (req_s) begin
               state_d      = ST_ACK;
               count_data_d = cnt_q;
               overflow_d   = sat_q;
               ack_d        = 1'b1;
               cnt_d        = '0;
               sat_d        = 1'b0;
            end else if (en_s) begin
               state_d = ST_COUNT;
               cnt_d   = cnt_inc;
               sat_d   = sat_inc;
            end
         end

         ST_ACK: begin
            cnt_d = '0;
            sat_d = 1'b0;
            if (!req_s) begin
               state_d = ST_IDLE;
               ack_d   = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
            ack_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge count_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sat_q        <= 1'b0;
         ack_q        <= 1'b0;
         count_data_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sat_q        <= sat_d;
         ack_q        <= ack_d;
         count_data_q <= count_data_d;
         overflow_q   <= overflow_d;
      end
   end

   assign ack        = ack_q;
   assign count_data = count_data_q;
   assign overflow   = overflow_q;
   assign busy       = ro_state_busy(state_q);

endmodule

// File: tb/tb_ro_count_sender.sv
// Scoreboard bench for ro_count_sender: a 16-bit and a 4-bit instance share
// one oscillator clock; a reference model predicts each captured window.
module tb_ro_count_sender;

   localparam int SYNC = 2;

   typedef struct {
      int cd;
      int ov;
   } exp_t;

   logic count_clk;
   logic rst [2];
   logic en  [2];
   logic req [2];

   logic        ack0, ack1, ovf0, ovf1, busy0, busy1;
   logic [15:0] cd0;
   logic [3:0]  cd1;

   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t q0[$];
   exp_t q1[$];

   int   acc   [2];
   int   ovm   [2];
   bit   in_hs [2];

   ro_count_sender #(.COUNT_W(16), .SYNC_STAGES(SYNC)) u_dut0 (
      .count_clk  (count_clk),
      .reset      (rst[0]),
      .en         (en[0]),
      .req        (req[0]),
      .ack        (ack0),
      .count_data (cd0),
      .overflow   (ovf0),
      .busy       (busy0)
   );

   ro_count_sender #(.COUNT_W(4), .SYNC_STAGES(SYNC)) u_dut1 (
      .count_clk  (count_clk),
      .reset      (rst[1]),
      .en         (en[1]),
      .req        (req[1]),
      .ack        (ack1),
      .count_data (cd1),
      .overflow   (ovf1),
      .busy       (busy1)
   );

   initial begin
      count_clk = 1'b0;
      forever #5 count_clk = ~count_clk;
   end

   function automatic int ack_of(input int d);
      return (d == 0) ? int'(ack0) : int'(ack1);
   endfunction

   function automatic int cd_of(input int d);
      return (d == 0) ? int'(cd0) : int'(cd1);
   endfunction

   function automatic int ov_of(input int d);
      return (d == 0) ? int'(ovf0) : int'(ovf1);
   endfunction

   function automatic int busy_of(input int d);
      return (d == 0) ? int'(busy0) : int'(busy1);
   endfunction

   function automatic int max_of(input int d);
      return (d == 0) ? 65535 : 15;
   endfunction

   task automatic check(input string name, input int d, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
      end
   endtask

   // Reference model: an edge counts when en is high outside a handshake;
   // a read captures the running total, and the first edge after req drops
   // is spent returning to idle. Synchronizer delay is identical for en and
   // req, so it shifts every event equally and drops out of the arithmetic.
   initial begin
      for (int d = 0; d < 2; d++) begin
         acc[d] = 0; ovm[d] = 0; in_hs[d] = 1'b0;
      end
      forever begin
         @(posedge count_clk);
         for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
               acc[d] = 0; ovm[d] = 0; in_hs[d] = 1'b0;
               if (d == 0) q0.delete(); else q1.delete();
            end else if (req[d]) begin
               if (!in_hs[d]) begin
                  exp_t e;
                  e.cd = acc[d];
                  e.ov = ovm[d];
                  if (d == 0) q0.push_back(e); else q1.push_back(e);
                  acc[d] = 0; ovm[d] = 0; in_hs[d] = 1'b1;
               end
            end else if (in_hs[d]) begin
               in_hs[d] = 1'b0;
            end else if (en[d]) begin
               if (acc[d] == max_of(d)) ovm[d] = 1;
               else acc[d] = acc[d] + 1;
            end
         end
      end
   end

   // Monitor: every ack rise pops one prediction; data must then hold still.
   initial begin
      int prev [2];
      int held [2];
      prev = '{0, 0};
      held = '{0, 0};
      forever begin
         @(negedge count_clk);
         for (int d = 0; d < 2; d++) begin
            int a;
            a = ack_of(d);
            if (!rst[d]) begin
               if (a == 1 && prev[d] == 0) begin
                  exp_t e;
                  if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL sb_unexpected_ack dut%0d: got ack with count %0d, expected no ack", d, cd_of(d));
                  end else begin
                     e = (d == 0) ? q0.pop_front() : q1.pop_front();
                     check("sb_count_data", d, cd_of(d), e.cd);
                     check("sb_overflow", d, ov_of(d), e.ov);
                     held[d] = e.cd;
                  end
               end else if (a == 1) begin
                  check("data_stable_in_ack", d, cd_of(d), held[d]);
               end
            end
            prev[d] = a;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge count_clk);
   endtask

   task automatic window(input int d, input int n);
      en[d] = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge count_clk);
         if (i == n / 2 && n >= 8) check("busy_counting", d, busy_of(d), 1);
      end
      en[d] = 1'b0;
   endtask

   // Full four-phase read; exp_cd < 0 leaves checking to the scoreboard only.
   task automatic handshake(input int d, input bit drop_en, input int exp_cd, input int exp_ov);
      int edges;
      req[d] = 1'b1;
      if (drop_en) en[d] = 1'b0;
      edges = 0;
      while (ack_of(d) != 1 && edges < 20) begin
         @(posedge count_clk); #1;
         edges++;
      end
      check("ack_rise_latency", d, edges, SYNC + 1);
      if (exp_cd >= 0) begin
         check("read_count_data", d, cd_of(d), exp_cd);
         check("read_overflow", d, ov_of(d), exp_ov);
      end
      @(negedge count_clk);
      req[d] = 1'b0;
      edges = 0;
      while (ack_of(d) != 0 && edges < 20) begin
         @(posedge count_clk); #1;
         edges++;
      end
      check("ack_fall_latency", d, edges, SYNC + 1);
      if (!en[d]) check("busy_after_read", d, busy_of(d), 0);
      @(negedge count_clk);
   endtask

   initial begin
      int edges;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; en[d] = 1'b0; req[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_ack", d, ack_of(d), 0);
         check("reset_count_data", d, cd_of(d), 0);
         check("reset_overflow", d, ov_of(d), 0);
         check("reset_busy", d, busy_of(d), 0);
      end
      tick(3);
      rst[0] = 1'b0; rst[1] = 1'b0;
      tick(2);

      // basic read of 1000 edges
      window(0, 1000);
      tick(4);
      handshake(0, 1'b0, 1000, 0);

      // saturation on the narrow instance, then a clean short window
      window(1, 40);
      tick(4);
      handshake(1, 1'b0, 15, 1);
      window(1, 5);
      tick(4);
      handshake(1, 1'b0, 5, 0);

      // read while counting; counting resumes from zero afterwards
      en[0] = 1'b1;
      tick(37);
      handshake(0, 1'b0, 37, 0);
      tick(20);
      en[0] = 1'b0;
      tick(4);
      handshake(0, 1'b0, -1, 0);

      // en falls on the same edge req rises
      en[0] = 1'b1;
      tick(50);
      handshake(0, 1'b1, 50, 0);

      // pause and resume
      window(0, 200);
      tick(50);
      window(0, 300);
      tick(5);
      handshake(0, 1'b0, 500, 0);

      // reset in the middle of an acknowledge
      window(0, 20);
      tick(4);
      req[0] = 1'b1;
      edges = 0;
      while (ack0 != 1'b1 && edges < 20) begin
         @(posedge count_clk); #1;
         edges++;
      end
      check("pre_reset_ack_latency", 0, edges, SYNC + 1);
      @(negedge count_clk);
      rst[0] = 1'b1;
      #1;
      check("reset_mid_ack_ack", 0, ack_of(0), 0);
      check("reset_mid_ack_data", 0, cd_of(0), 0);
      check("reset_mid_ack_busy", 0, busy_of(0), 0);
      tick(2);
      rst[0] = 1'b0;
      edges = 0;
      while (ack0 != 1'b1 && edges < 20) begin
         @(posedge count_clk); #1;
         edges++;
      end
      check("post_reset_ack_edge", 0, edges, SYNC + 1);
      check("post_reset_count_data", 0, cd_of(0), 0);
      @(negedge count_clk);
      req[0] = 1'b0;
      tick(6);
      check("post_reset_idle_ack", 0, ack_of(0), 0);

      // randomized windows, gaps and reads on both instances
      for (int it = 0; it < 16; it++) begin
         int d;
         int nwin;
         d = int'($urandom_range(0, 1));
         nwin = int'($urandom_range(1, 3));
         for (int w = 0; w < nwin; w++) begin
            window(d, (d == 0) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 12)));
            tick(int'($urandom_range(0, 10)));
         end
         if ($urandom_range(0, 2) == 0) begin
            en[d] = 1'b1;
            tick(int'($urandom_range(1, 30)));
            handshake(d, 1'b0, -1, 0);
            tick(int'($urandom_range(0, 15)));
            en[d] = 1'b0;
            tick(4);
         end
         handshake(d, $urandom_range(0, 1) == 1, -1, 0);
      end

      tick(10);
      if (q0.size() != 0 || q1.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_leftover: got %0d/%0d pending predictions, expected 0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
